// File: rtl/pipe_reg_if_id_v2_if.sv
// rtl/pipe_reg_if_id_v2_if.sv - IF/ID pipeline register bus bundle
//
// Groups the fetch-side inputs and the decode-side registered outputs of the
// IF/ID pipeline register.
//   master : driven by fetch/hazard logic (flush, stall, in_valid, *_hat),
//            observes the registered outputs
//   slave  : the pipeline register itself
// Optional PIPE_REG_PERF_CNT_EN adds stall_cnt / flush_cnt to the bundle.
interface pipe_reg_if_id_v2_if #(
  parameter int INST_LENGTH = 32,
  parameter int DATA_LENGTH = 32,
  parameter int PC_LENGTH   = 32
) ();
  logic                   flush;
  logic                   stall;
  logic                   in_valid;
  logic [INST_LENGTH-1:0] inst_hat;
  logic [DATA_LENGTH-1:0] dataA_hat;
  logic [DATA_LENGTH-1:0] dataB_hat;
  logic [PC_LENGTH-1:0]   PC_hat;
  logic [INST_LENGTH-1:0] inst;
  logic [DATA_LENGTH-1:0] dataA;
  logic [DATA_LENGTH-1:0] dataB;
  logic [PC_LENGTH-1:0]   PC;
  logic                   valid;
  logic                   squashing;
`ifdef PIPE_REG_PERF_CNT_EN
  logic [31:0]            stall_cnt;
  logic [31:0]            flush_cnt;
`endif

  modport master (
    output flush, stall, in_valid, inst_hat, dataA_hat, dataB_hat, PC_hat,
    input  inst, dataA, dataB, PC, valid, squashing
`ifdef PIPE_REG_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  flush, stall, in_valid, inst_hat, dataA_hat, dataB_hat, PC_hat,
    output inst, dataA, dataB, PC, valid, squashing
`ifdef PIPE_REG_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_reg_if_id_v2.sv
// rtl/pipe_reg_if_id_v2.sv - IF/ID pipeline register with stall, valid, bubbles and flush window
//
// Carries instruction, two operand words and PC from fetch into decode.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_reg_if_id_v2_if.slave
//           in : flush, stall, in_valid, inst_hat, dataA_hat, dataB_hat, PC_hat
//           out: inst, dataA, dataB, PC, valid, squashing
//                (stall_cnt, flush_cnt when PIPE_REG_PERF_CNT_EN is defined)
// A flush pulse squashes FLUSH_DEPTH consecutive non-stalled edges; squashing
// is high while further squash edges remain.
module pipe_reg_if_id_v2 #(
  parameter int                     INST_LENGTH = 32,
  parameter int                     DATA_LENGTH = 32,
  parameter int                     PC_LENGTH   = 32,
  parameter logic [INST_LENGTH-1:0] NOP_INST    = 32'h00000033,
  parameter int                     FLUSH_DEPTH = 1
) (
  input logic                clk,
  input logic                rst_n,
  pipe_reg_if_id_v2_if.slave bus
);

  // Counter must hold FLUSH_DEPTH-1; keep at least one bit even when depth is 1.
  localparam int              SQ_W     = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [SQ_W-1:0] SQ_START = SQ_W'(FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_t;

  act_t            act;
  logic [SQ_W-1:0] sq_cnt;
  logic [SQ_W-1:0] sq_next;

  // Edge action in priority order: flush, window (hold/bubble), stall, bubble, load.
  always_comb begin
    act     = ACT_HOLD;
    sq_next = sq_cnt;
    if (bus.flush) begin
      act     = ACT_BUBBLE;
      sq_next = SQ_START;
    end else if (sq_cnt != '0) begin
      if (!bus.stall) begin
        act     = ACT_BUBBLE;
        sq_next = sq_cnt - SQ_W'(1);
      end
    end else if (!bus.stall) begin
      act = bus.in_valid ? ACT_LOAD : ACT_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.inst      <= NOP_INST;
      bus.dataA     <= '0;
      bus.dataB     <= '0;
      bus.PC        <= '0;
      bus.valid     <= 1'b0;
      bus.squashing <= 1'b0;
      sq_cnt        <= '0;
    end else begin
      case (act)
        ACT_BUBBLE: begin
          bus.inst  <= NOP_INST;
          bus.dataA <= '0;
          bus.dataB <= '0;
          bus.PC    <= '0;
          bus.valid <= 1'b0;
        end
        ACT_LOAD: begin
          bus.inst  <= bus.inst_hat;
          bus.dataA <= bus.dataA_hat;
          bus.dataB <= bus.dataB_hat;
          bus.PC    <= bus.PC_hat;
          bus.valid <= 1'b1;
        end
        default: ;
      endcase
      sq_cnt        <= sq_next;
      bus.squashing <= (sq_next != '0);
    end
  end

`ifdef PIPE_REG_PERF_CNT_EN
  // Saturating event counters; a flush edge is never counted as a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (bus.stall && !bus.flush && (bus.stall_cnt != 32'hFFFFFFFF))
        bus.stall_cnt <= bus.stall_cnt + 32'd1;
      if (bus.flush && (bus.flush_cnt != 32'hFFFFFFFF))
        bus.flush_cnt <= bus.flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_if_id_v2.sv
// tb/tb_pipe_reg_if_id_v2.sv - self-checking bench for pipe_reg_if_id_v2 (FLUSH_DEPTH 1 and 3)
module tb_pipe_reg_if_id_v2;
  localparam logic [31:0] NOP = 32'h00000033;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush_d, stall_d, valid_d;
  logic [31:0] inst_d, a_d, b_d, pc_d;

  pipe_reg_if_id_v2_if #(.INST_LENGTH(32), .DATA_LENGTH(32), .PC_LENGTH(32)) if1 ();
  pipe_reg_if_id_v2_if #(.INST_LENGTH(32), .DATA_LENGTH(32), .PC_LENGTH(32)) if3 ();

  assign if1.flush = flush_d;  assign if3.flush = flush_d;
  assign if1.stall = stall_d;  assign if3.stall = stall_d;
  assign if1.in_valid = valid_d; assign if3.in_valid = valid_d;
  assign if1.inst_hat = inst_d; assign if3.inst_hat = inst_d;
  assign if1.dataA_hat = a_d;  assign if3.dataA_hat = a_d;
  assign if1.dataB_hat = b_d;  assign if3.dataB_hat = b_d;
  assign if1.PC_hat = pc_d;    assign if3.PC_hat = pc_d;

  pipe_reg_if_id_v2 #(.INST_LENGTH(32), .DATA_LENGTH(32), .PC_LENGTH(32),
                      .NOP_INST(NOP), .FLUSH_DEPTH(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipe_reg_if_id_v2 #(.INST_LENGTH(32), .DATA_LENGTH(32), .PC_LENGTH(32),
                      .NOP_INST(NOP), .FLUSH_DEPTH(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int checks = 0;
  int passes = 0;

  // Reference model: index 0 -> depth 1, index 1 -> depth 3.
  int          depth [2] = '{1, 3};
  logic [31:0] m_inst[2], m_a[2], m_b[2], m_pc[2];
  logic        m_v[2];
  int          m_rem[2];
  longint      m_sc, m_fc;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_inst[k] = NOP; m_a[k] = 0; m_b[k] = 0; m_pc[k] = 0; m_v[k] = 0; m_rem[k] = 0;
    end
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_bubble(input int k);
    m_inst[k] = NOP; m_a[k] = 0; m_b[k] = 0; m_pc[k] = 0; m_v[k] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (flush_d) begin
        model_bubble(k);
        m_rem[k] = depth[k] - 1;
      end else if (m_rem[k] > 0) begin
        if (!stall_d) begin
          model_bubble(k);
          m_rem[k] = m_rem[k] - 1;
        end
      end else if (stall_d) begin
        // hold
      end else if (!valid_d) begin
        model_bubble(k);
      end else begin
        m_inst[k] = inst_d; m_a[k] = a_d; m_b[k] = b_d; m_pc[k] = pc_d; m_v[k] = 1;
      end
    end
    if (stall_d && !flush_d && m_sc < 64'hFFFFFFFF) m_sc++;
    if (flush_d && m_fc < 64'hFFFFFFFF) m_fc++;
  endtask

  function automatic logic [129:0] exp_vec(input int k);
    return {m_inst[k], m_a[k], m_b[k], m_pc[k], m_v[k], (m_rem[k] != 0)};
  endfunction

  function automatic logic [129:0] act_vec(input int k);
    if (k == 0) return {if1.inst, if1.dataA, if1.dataB, if1.PC, if1.valid, if1.squashing};
    return {if3.inst, if3.dataA, if3.dataB, if3.PC, if3.valid, if3.squashing};
  endfunction

  task automatic drive(input logic f, input logic s, input logic v, input logic [31:0] pc);
    flush_d = f; stall_d = s; valid_d = v;
    inst_d = $urandom; a_d = $urandom; b_d = $urandom; pc_d = pc;
  endtask

  // One rising edge; returns at the following falling edge for sampling.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 32'h100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (if1.inst !== NOP || if1.PC !== 0 || if1.valid !== 0 || if3.squashing !== 0) begin
      $display("FAIL reset_state got inst=%h pc=%h v=%b sq=%b exp inst=%h pc=0 v=0 sq=0",
               if1.inst, if1.PC, if1.valid, if3.squashing, NOP);
    end else passes++;
  endtask

  task automatic test_normal();
    drive(0, 0, 1, 32'h4);
    inst_d = 32'h00500093; a_d = 7; b_d = 9;
    cycle();
    checks++;
    if ({if1.inst, if1.dataA, if1.dataB, if1.PC, if1.valid} !==
        {32'h00500093, 32'd7, 32'd9, 32'd4, 1'b1}) begin
      $display("FAIL normal_load got inst=%h a=%0d b=%0d pc=%h v=%b exp 00500093/7/9/4/1",
               if1.inst, if1.dataA, if1.dataB, if1.PC, if1.valid);
    end else passes++;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== exp_vec(k))
        $display("FAIL normal_model dut%0d got %h exp %h", k, act_vec(k), exp_vec(k));
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== exp_vec(k))
        $display("FAIL async_reset dut%0d got %h exp %h", k, act_vec(k), exp_vec(k));
      else passes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 32'd8);
    cycle();
    for (int e = 0; e < 3; e++) begin
      drive(0, 1, 1, 32'd12 + 32'd4 * e);
      cycle();
      checks++;
      if (if1.PC !== 32'd8 || if1.valid !== 1'b1 || if3.PC !== 32'd8)
        $display("FAIL stall_hold edge%0d got pc=%0d/%0d v=%b exp pc=8 v=1",
                 e, if1.PC, if3.PC, if1.valid);
      else passes++;
    end
    drive(0, 0, 1, 32'd20);
    cycle();
    checks++;
    if (if1.PC !== 32'd20 || if3.PC !== 32'd20 || if3.valid !== 1'b1)
      $display("FAIL stall_release got pc=%0d/%0d v=%b exp pc=20 v=1", if1.PC, if3.PC, if3.valid);
    else passes++;
  endtask

  task automatic test_flush_beats_stall();
    drive(1, 1, 1, 32'h300);
    cycle();
    checks++;
    if (if1.inst !== NOP || if1.PC !== 0 || if1.valid !== 0 || if3.valid !== 0 || if3.squashing !== 1)
      $display("FAIL flush_over_stall got inst=%h pc=%h v=%b/%b sq3=%b exp %h/0/0/0/1",
               if1.inst, if1.PC, if1.valid, if3.valid, if3.squashing, NOP);
    else passes++;
    drive(0, 0, 1, 32'h304);
    repeat (3) cycle();
  endtask

  task automatic test_flush_window();
    logic exp_sq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int e = 0; e < 4; e++) begin
      drive(e == 0, 0, 1, 32'd40 + 32'd4 * e);
      cycle();
      checks++;
      if (if3.squashing !== exp_sq[e] || if3.valid !== (e == 3))
        $display("FAIL window3 edge%0d got sq=%b v=%b exp sq=%b v=%b",
                 e + 1, if3.squashing, if3.valid, exp_sq[e], (e == 3));
      else passes++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k))
          $display("FAIL window_model dut%0d edge%0d got %h exp %h", k, e + 1, act_vec(k), exp_vec(k));
        else passes++;
      end
    end
    checks++;
    if (if3.PC !== 32'd52 || if1.PC !== 32'd52)
      $display("FAIL window_exit got pc=%0d/%0d exp 52", if1.PC, if3.PC);
    else passes++;
  endtask

  task automatic test_window_stall();
    logic s_pat[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int e = 0; e < 6; e++) begin
      drive(e == 0, s_pat[e], 1, 32'd100 + 32'd4 * e);
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k))
          $display("FAIL window_stall dut%0d edge%0d got %h exp %h", k, e + 1, act_vec(k), exp_vec(k));
        else passes++;
      end
    end
    checks++;
    if (if3.PC !== 32'd120 || if3.valid !== 1'b1)
      $display("FAIL window_stall_exit got pc=%0d v=%b exp pc=120 v=1", if3.PC, if3.valid);
    else passes++;
  endtask

  task automatic test_reset_mid_window();
    drive(1, 0, 1, 32'h500);
    cycle();
    drive(0, 0, 1, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (if3.squashing !== 1'b0 || if3.valid !== 1'b0)
      $display("FAIL reset_mid_window got sq=%b v=%b exp 0/0", if3.squashing, if3.valid);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 32'h508);
    cycle();
    checks++;
    if (if3.PC !== 32'h508 || if3.valid !== 1'b1 || if3.squashing !== 1'b0)
      $display("FAIL after_reset_load got pc=%h v=%b sq=%b exp 508/1/0", if3.PC, if3.valid, if3.squashing);
    else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) != 0, $urandom);
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k))
          $display("FAIL random dut%0d cyc%0d got %h exp %h", k, n, act_vec(k), exp_vec(k));
        else passes++;
      end
    end
`ifdef PIPE_REG_PERF_CNT_EN
    checks++;
    if ({if1.stall_cnt, if1.flush_cnt, if3.stall_cnt, if3.flush_cnt} !==
        {m_sc[31:0], m_fc[31:0], m_sc[31:0], m_fc[31:0]})
      $display("FAIL perf_cnt got s=%0d f=%0d exp s=%0d f=%0d", if1.stall_cnt, if1.flush_cnt, m_sc, m_fc);
    else passes++;
`endif
  endtask

  initial begin
    drive(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_normal();
    test_async_reset();
    test_stall();
    test_flush_beats_stall();
    test_flush_window();
    test_window_stall();
    test_reset_mid_window();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
